// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol stream generator.
//   state_e   : controller state (IDLE, INIT, RUN)
//   JK_TBL    : Joe-Kuo new-joe-kuo-6 rows for dims 0..63. Each row holds
//               {degree s, coefficient a, m1..m9}. Dim 0 is the van der
//               Corput dimension and has no polynomial.
//   sobol_dir : direction number v[d][b], left-aligned to a given width
//   ctz_ones  : trailing-one count, used to pick the bit that flips in Gray order
package sobol_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;

  localparam int MAX_DIMS = 64;
  localparam int JK_COLS  = 11;

  localparam int unsigned JK_TBL [MAX_DIMS][JK_COLS] = '{
    '{0,  0, 0,0,0,0,0,0,0,0,0},            '{1,  0, 1,0,0,0,0,0,0,0,0},
    '{2,  1, 1,3,0,0,0,0,0,0,0},            '{3,  1, 1,3,1,0,0,0,0,0,0},
    '{3,  2, 1,1,1,0,0,0,0,0,0},            '{4,  1, 1,1,3,3,0,0,0,0,0},
    '{4,  4, 1,3,5,13,0,0,0,0,0},           '{5,  2, 1,1,5,5,17,0,0,0,0},
    '{5,  4, 1,1,5,5,5,0,0,0,0},            '{5,  7, 1,1,7,11,19,0,0,0,0},
    '{5, 11, 1,1,5,1,1,0,0,0,0},            '{5, 13, 1,1,1,3,11,0,0,0,0},
    '{5, 14, 1,3,5,5,31,0,0,0,0},           '{6,  1, 1,3,3,9,7,49,0,0,0},
    '{6, 13, 1,1,1,15,21,21,0,0,0},         '{6, 16, 1,3,1,13,27,49,0,0,0},
    '{6, 19, 1,1,1,15,7,5,0,0,0},           '{6, 22, 1,3,1,15,13,25,0,0,0},
    '{6, 25, 1,1,5,5,19,61,0,0,0},          '{7,  1, 1,3,7,11,23,15,103,0,0},
    '{7,  4, 1,3,7,13,13,15,69,0,0},        '{7,  7, 1,1,3,13,7,35,63,0,0},
    '{7,  8, 1,3,5,9,1,25,53,0,0},          '{7, 14, 1,3,1,13,9,35,107,0,0},
    '{7, 19, 1,3,1,5,27,61,31,0,0},         '{7, 21, 1,1,5,11,19,41,61,0,0},
    '{7, 28, 1,3,5,3,3,13,69,0,0},          '{7, 31, 1,1,7,13,1,19,1,0,0},
    '{7, 32, 1,3,7,5,13,19,59,0,0},         '{7, 37, 1,1,3,9,25,29,41,0,0},
    '{7, 41, 1,3,5,13,23,1,55,0,0},         '{7, 42, 1,3,7,3,13,59,17,0,0},
    '{7, 50, 1,3,1,3,5,53,69,0,0},          '{7, 55, 1,1,5,5,23,33,13,0,0},
    '{7, 56, 1,1,7,7,1,61,123,0,0},         '{7, 59, 1,1,7,9,13,61,49,0,0},
    '{7, 62, 1,3,3,5,3,55,33,0,0},          '{8, 14, 1,3,1,15,31,13,49,245,0},
    '{8, 21, 1,3,5,15,31,59,63,97,0},       '{8, 22, 1,3,1,11,11,11,77,249,0},
    '{8, 38, 1,3,1,11,27,43,71,9,0},        '{8, 47, 1,1,7,15,21,11,81,45,0},
    '{8, 49, 1,3,7,3,25,31,65,79,0},        '{8, 50, 1,3,1,1,19,11,3,205,0},
    '{8, 52, 1,1,5,9,19,21,29,157,0},       '{8, 56, 1,3,7,11,1,33,89,185,0},
    '{8, 67, 1,3,3,3,15,9,79,71,0},         '{8, 70, 1,3,7,11,15,39,119,27,0},
    '{8, 84, 1,1,3,1,11,31,97,225,0},       '{8, 97, 1,1,1,3,23,43,57,177,0},
    '{8,103, 1,3,7,7,17,17,37,71,0},        '{8,115, 1,3,1,5,27,63,123,213,0},
    '{8,122, 1,1,3,5,11,43,53,133,0},       '{9,  8, 1,3,5,5,29,17,47,173,479},
    '{9, 13, 1,3,3,11,3,1,109,9,69},        '{9, 16, 1,1,1,5,17,39,23,5,343},
    '{9, 22, 1,3,1,5,25,15,31,103,499},     '{9, 25, 1,1,1,11,11,17,63,105,183},
    '{9, 44, 1,1,5,11,9,29,97,231,363},     '{9, 47, 1,1,5,15,19,45,41,7,383},
    '{9, 52, 1,3,7,11,23,47,9,163,293},     '{9, 55, 1,1,7,3,11,25,109,107,141},
    '{9, 59, 1,1,3,11,9,49,123,93,331},     '{9, 62, 1,3,7,7,27,41,47,155,125}
  };

  // v[d][b] = m_{b+1} << (width-1-b); m_k past the table follows the
  // primitive-polynomial recurrence. Bits at or beyond width give 0.
  function automatic logic [63:0] sobol_dir(int d, int b, int width);
    logic [63:0] m [1:64];
    int s;
    int a;
    if (b >= width) return '0;
    if (d == 0) return 64'(1) << (width - 1 - b);
    s = int'(JK_TBL[d][0]);
    a = int'(JK_TBL[d][1]);
    for (int k = 1; k <= b + 1; k++) begin
      if (k <= s) begin
        m[k] = 64'(JK_TBL[d][k+1]);
      end else begin
        m[k] = m[k-s] ^ (m[k-s] << s);
        for (int i = 1; i < s; i++)
          if (((a >> (s - 1 - i)) & 1) != 0) m[k] = m[k] ^ (m[k-i] << i);
      end
    end
    return m[b+1] << (width - 1 - b);
  endfunction

  function automatic int ctz_ones(logic [63:0] n);
    int  c;
    logic run;
    c   = 0;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (run && n[i]) c = c + 1;
      else run = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/sobol_stream_if.sv
// Command and point-stream bundle for sobol_stream.
//   master : the generator (takes start/start_idx/num_pts/out_ready,
//            drives out_valid/out_data/out_idx/out_last/busy/done/ovf)
//   slave  : the requester/consumer side
interface sobol_stream_if #(
  parameter int DIMS  = 8,
  parameter int WIDTH = 32,
  parameter int IDX_W = 32
);
  logic                  start;
  logic [IDX_W-1:0]      start_idx;
  logic [IDX_W-1:0]      num_pts;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIMS*WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (
    input  start, start_idx, num_pts, out_ready,
    output out_valid, out_data, out_idx, out_last, busy, done, ovf
  );

  modport slave (
    output start, start_idx, num_pts, out_ready,
    input  out_valid, out_data, out_idx, out_last, busy, done, ovf
  );
endinterface

// File: rtl/sobol_dir_rom.sv
// Direction-number ROM: for one bit index, returns v[d][bit] for every dim.
//   bit_i : direction bit index b (0..IDX_W-1)
//   dir_o : v[d][b] for all dims, dim d at [d*WIDTH +: WIDTH]
module sobol_dir_rom
  import sobol_pkg::*;
#(
  parameter  int DIMS  = 8,
  parameter  int WIDTH = 32,
  parameter  int IDX_W = 32,
  localparam int BIT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1
) (
  input  logic [BIT_W-1:0]      bit_i,
  output logic [DIMS*WIDTH-1:0] dir_o
);

  function automatic logic [IDX_W*WIDTH-1:0] build_tbl(int d);
    logic [IDX_W*WIDTH-1:0] t;
    t = '0;
    for (int b = 0; b < IDX_W; b++) t[b*WIDTH +: WIDTH] = WIDTH'(sobol_dir(d, b, WIDTH));
    return t;
  endfunction

  for (genvar gi = 0; gi < DIMS; gi++) begin : g_dim
    localparam logic [IDX_W*WIDTH-1:0] TBL = build_tbl(gi);
    logic [WIDTH-1:0] v_sel;

    always_comb begin
      v_sel = '0;
      for (int b = 0; b < IDX_W; b++)
        if (bit_i == BIT_W'(b)) v_sel = TBL[b*WIDTH +: WIDTH];
    end

    assign dir_o[gi*WIDTH +: WIDTH] = v_sel;
  end

endmodule

// File: rtl/sobol_stream.sv
// Multi-dimensional Sobol point generator (Antonov-Saleev Gray-code order).
//   clk, rst : clock, synchronous active-high reset
//   bus      : sobol_stream_if.master - start/start_idx/num_pts request,
//              out_valid/out_ready stream of out_data/out_idx/out_last,
//              busy level, done and ovf completion pulses
// INIT builds x(n0) bit by bit from gray(n0); RUN then steps one XOR per
// dim per accepted point.
module sobol_stream
  import sobol_pkg::*;
#(
  parameter int DIMS  = 8,
  parameter int WIDTH = 32,
  parameter int IDX_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  sobol_stream_if.master bus
);

  localparam int BIT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;
  localparam logic [BIT_W-1:0] K_LAST = BIT_W'(IDX_W - 1);

  state_e                state_q;
  logic [DIMS*WIDTH-1:0] x_q;
  logic [IDX_W-1:0]      n_q;
  logic [IDX_W-1:0]      rem_q;
  logic [BIT_W-1:0]      k_q;
  logic                  out_valid_q;
  logic                  done_q;
  logic                  ovf_q;

  logic [IDX_W-1:0]      gray_n;
  logic [BIT_W-1:0]      rom_bit;
  logic [DIMS*WIDTH-1:0] dir_v;

  assign gray_n = n_q ^ (n_q >> 1);

  // INIT walks the bits of gray(n0); RUN needs the bit that flips between
  // gray(n) and gray(n+1). When n is all ones the count wraps, but that
  // handshake ends the run with ovf so the value is never used.
  assign rom_bit = (state_q == RUN) ? BIT_W'(ctz_ones(64'(n_q))) : k_q;

  sobol_dir_rom #(
    .DIMS  (DIMS),
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_rom (
    .bit_i (rom_bit),
    .dir_o (dir_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      n_q         <= '0;
      rem_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_pts == '0) begin
              done_q <= 1'b1;
            end else begin
              n_q     <= bus.start_idx;
              rem_q   <= bus.num_pts;
              x_q     <= '0;
              k_q     <= '0;
              state_q <= INIT;
            end
          end
        end
        INIT: begin
          if (gray_n[k_q]) x_q <= x_q ^ dir_v;
          k_q <= k_q + BIT_W'(1);
          if (k_q == K_LAST) begin
            state_q     <= RUN;
            out_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (out_valid_q && bus.out_ready) begin
            if (rem_q == IDX_W'(1)) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else if (&n_q) begin
              out_valid_q <= 1'b0;
              ovf_q       <= 1'b1;
              state_q     <= IDLE;
            end else begin
              x_q   <= x_q ^ dir_v;
              n_q   <= n_q + IDX_W'(1);
              rem_q <= rem_q - IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = x_q;
  assign bus.out_idx   = n_q;
  assign bus.out_last  = (rem_q == IDX_W'(1));
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sobol_stream.sv
module tb_sobol_stream;

  localparam int DIMS  = 8;
  localparam int WIDTH = 32;
  localparam int IDX_W = 32;

  // Hand-derived m1..m4 for dims 0..7; enough for any gray code below 16.
  localparam int unsigned M4 [8][4] = '{
    '{1,1,1,1}, '{1,3,5,15}, '{1,3,3,9}, '{1,3,1,5},
    '{1,1,1,11}, '{1,1,3,3}, '{1,3,5,13}, '{1,1,5,5}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  sobol_stream_if #(.DIMS(DIMS), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  sobol_stream #(.DIMS(DIMS), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_x(int d, logic [31:0] g);
    logic [31:0] x;
    x = '0;
    for (int b = 0; b < 4; b++)
      if (g[b]) x = x ^ (M4[d][b] << (31 - b));
    return x;
  endfunction

  task automatic check_point(input logic [31:0] n, input bit last);
    logic [31:0] g;
    g = n ^ (n >> 1);
    $display("point n=%0d data=%h last=%0b", n, bus.out_data, bus.out_last);
    check($sformatf("idx_n%0d", n), bus.out_idx, n);
    check($sformatf("last_n%0d", n), bus.out_last, last);
    for (int d = 0; d < DIMS; d++)
      check($sformatf("data_d%0d_n%0d", d, n), bus.out_data[d*WIDTH +: WIDTH], exp_x(d, g));
  endtask

  task automatic start_req(input logic [31:0] n0, input logic [31:0] cnt);
    bus.start     = 1'b1;
    bus.start_idx = n0;
    bus.num_pts   = cnt;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid();
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("first_valid_latency", 256'(lat), 256'(33));
  endtask

  task automatic run_points(input logic [31:0] n0, input int npts, input bit bp);
    int          got;
    int          budget;
    bit          stalled;
    bit          rdy;
    logic [255:0] held_data;
    logic [31:0]  held_idx;
    start_req(n0, 32'(npts));
    wait_valid();
    got = 0; budget = 0; stalled = 1'b0;
    held_data = '0; held_idx = '0;
    while (got < npts && budget < 400) begin
      budget++;
      check("valid_high", bus.out_valid, 1'b1);
      if (!bus.out_valid) break;
      if (stalled) begin
        check("hold_data", bus.out_data, held_data);
        check("hold_idx", bus.out_idx, held_idx);
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      if (rdy) begin
        check_point(n0 + 32'(got), got == npts - 1);
        got++;
        stalled = 1'b0;
      end else begin
        held_data = bus.out_data;
        held_idx  = bus.out_idx;
        stalled   = 1'b1;
      end
      step();
    end
    check("points_taken", 256'(got), 256'(npts));
    check("done_pulse", bus.done, 1'b1);
    check("no_ovf", bus.ovf, 1'b0);
    check("valid_after_done", bus.out_valid, 1'b0);
    step();
    check("done_clears", bus.done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.start_idx = '0; bus.num_pts = '0; bus.out_ready = 1'b0;
    step(); step(); step();
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_idx", bus.out_idx, 32'h0);
    check("rst_data", bus.out_data, 256'h0);
    check("rst_last", bus.out_last, 1'b0);
    rst = 1'b0;
    step();

    // dims 0/1 from index 0 with continuous ready
    run_points(32'd0, 6, 1'b0);
    // skip-ahead start, all dims
    run_points(32'd10, 4, 1'b0);
    // random backpressure
    run_points(32'd0, 12, 1'b1);

    // index-space exhaustion
    bus.out_ready = 1'b0;
    start_req(32'hFFFF_FFFE, 32'd5);
    wait_valid();
    bus.out_ready = 1'b1;
    $display("point n=%h data=%h", bus.out_idx, bus.out_data);
    check("ovf_idx0", bus.out_idx, 32'hFFFF_FFFE);
    check("ovf_d0_0", bus.out_data[31:0], 32'h8000_0001);
    check("ovf_d1_0", bus.out_data[63:32], 32'h7FFF_FFFF);
    step();
    $display("point n=%h data=%h", bus.out_idx, bus.out_data);
    check("ovf_valid1", bus.out_valid, 1'b1);
    check("ovf_idx1", bus.out_idx, 32'hFFFF_FFFF);
    check("ovf_d0_1", bus.out_data[31:0], 32'h0000_0001);
    check("ovf_d1_1", bus.out_data[63:32], 32'hFFFF_FFFF);
    step();
    check("ovf_pulse", bus.ovf, 1'b1);
    check("ovf_no_done", bus.done, 1'b0);
    check("ovf_valid_low", bus.out_valid, 1'b0);
    step();
    check("ovf_clears", bus.ovf, 1'b0);
    check("ovf_idle", bus.busy, 1'b0);

    // zero-length request
    start_req(32'd7, 32'd0);
    $display("zero-length request done=%0b valid=%0b", bus.done, bus.out_valid);
    check("zero_done", bus.done, 1'b1);
    check("zero_valid", bus.out_valid, 1'b0);
    check("zero_busy", bus.busy, 1'b0);
    step();
    check("zero_done_clears", bus.done, 1'b0);

    // start ignored while busy, then reset mid-RUN
    bus.out_ready = 1'b0;
    start_req(32'd0, 32'd10);
    wait_valid();
    start_req(32'd99, 32'd1);
    $display("start while busy idx=%0d valid=%0b", bus.out_idx, bus.out_valid);
    check("busy_start_idx", bus.out_idx, 32'd0);
    check("busy_start_valid", bus.out_valid, 1'b1);
    check("busy_start_last", bus.out_last, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset mid-run valid=%0b busy=%0b done=%0b", bus.out_valid, bus.busy, bus.done);
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    step();
    check("abort_no_done", bus.done, 1'b0);
    run_points(32'd3, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
